// File: rtl/vrvv_pkg.sv
// Shared vector-unit definitions: vtype field layout, sequencer states and beat decode helpers.
package vrvv_pkg;

  localparam int unsigned VLEN        = 128;
  localparam int unsigned VLENB       = VLEN / 8;
  localparam int unsigned REG_AW      = 5;
  localparam int unsigned VL_W        = 9;
  localparam int unsigned EVL_W       = 8;
  localparam int unsigned BEAT_W      = 3;
  localparam int unsigned VTYPE_W     = 7;
  localparam int unsigned VTYPE_VALID = 6;
  localparam int unsigned VSEW_LSB    = 3;
  localparam int unsigned VLMUL_LSB   = 0;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, ERR, ZERO} state_t;

  // Integral LMUL 1..8 and SEW 8..64 only; the top bit of each field selects the reserved/fractional encodings.
  function automatic logic vtype_legal(input logic [VTYPE_W-1:0] vtype);
    return vtype[VTYPE_VALID] && !vtype[VSEW_LSB+2] && !vtype[VLMUL_LSB+2];
  endfunction

  // Byte mask of register i of a group: active elements clamped to [0, EPR], scaled to bytes.
  function automatic logic [VLENB-1:0] beat_bmask(input logic [EVL_W-1:0] evl,
                                                  input logic [BEAT_W-1:0] i,
                                                  input logic [1:0] vsew);
    logic [4:0]       epr;
    logic [7:0]       base;
    logic [7:0]       cnt;
    logic [VLENB:0]   ones;
    epr  = 5'd16 >> vsew;
    base = 8'(i) * 8'(epr);
    if (evl <= base)
      cnt = 8'd0;
    else if ((evl - base) >= 8'(epr))
      cnt = 8'(epr);
    else
      cnt = evl - base;
    ones = (17'd1 << (cnt << vsew)) - 17'd1;
    return ones[VLENB-1:0];
  endfunction

endpackage

// File: rtl/vrf_wb_pipe.sv
// Fixed-latency {valid, write address} delay line matching the vector ALU pipeline depth.
module vrf_wb_pipe
  import vrvv_pkg::*;
#(
  parameter int unsigned LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] in_wa,
  output logic              out_valid,
  output logic [REG_AW-1:0] out_wa
);

  logic [LAT-1:0]    vld_q;
  logic [REG_AW-1:0] wa_q [LAT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      for (int k = 0; k < int'(LAT); k++) wa_q[k] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      wa_q[0]  <= in_wa;
      for (int k = 1; k < int'(LAT); k++) begin
        vld_q[k] <= vld_q[k-1];
        wa_q[k]  <= wa_q[k-1];
      end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_wa    = wa_q[LAT-1];

endmodule

// File: rtl/vrf_group_sequencer.sv
// Issues one register-group vector op through the VRF, one register per cycle, and writes results back.
module vrf_group_sequencer
  import vrvv_pkg::*;
#(
  parameter int unsigned ALU_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [REG_AW-1:0]  cmd_vd,
  input  logic [REG_AW-1:0]  cmd_vs1,
  input  logic [REG_AW-1:0]  cmd_vs2,
  input  logic [VTYPE_W-1:0] vtype,
  input  logic [VL_W-1:0]    vl,
  output logic [REG_AW-1:0]  raA,
  output logic [REG_AW-1:0]  raB,
  output logic               alu_valid,
  output logic [VLENB-1:0]   alu_bmask,
  input  logic [VLEN-1:0]    alu_res,
  output logic [REG_AW-1:0]  wa,
  output logic [VLEN-1:0]    wd,
  output logic               wen,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d, drain_q, drain_d, last_q;
  logic [1:0]          vsew_q;
  logic [EVL_W-1:0]    evl_q;
  logic [REG_AW-1:0]   vd_q, vs1_q, vs2_q;
  logic                accept;

  logic [1:0]          dec_vsew, dec_vlmul;
  logic [BEAT_W-1:0]   dec_last;
  logic [EVL_W-1:0]    dec_vlmax, dec_evl;
  logic                dec_legal;

  logic [1:0]          cur_vsew;
  logic [EVL_W-1:0]    cur_evl;
  logic [REG_AW-1:0]   cur_vd, cur_vs1, cur_vs2;
  logic                issuing_d, idle_like_d, done_d, err_d;
  logic [VLENB-1:0]    bmask_d;
  logic [REG_AW-1:0]   raA_d, raB_d, issue_wa_d, issue_wa;

  assign accept = cmd_valid & cmd_ready;

  // Command decode, only meaningful in the acceptance cycle.
  always_comb begin
    dec_vsew  = vtype[VSEW_LSB +: 2];
    dec_vlmul = vtype[VLMUL_LSB +: 2];
    dec_last  = 3'((4'd1 << dec_vlmul) - 4'd1);
    dec_vlmax = 8'((9'd16 >> dec_vsew) << dec_vlmul);
    dec_evl   = (vl > 9'(dec_vlmax)) ? dec_vlmax : vl[EVL_W-1:0];
    dec_legal = vtype_legal(vtype) &&
                (((cmd_vd | cmd_vs1 | cmd_vs2) & 5'(dec_last)) == 5'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vsew_q <= '0;
      evl_q  <= '0;
      last_q <= '0;
      vd_q   <= '0;
      vs1_q  <= '0;
      vs2_q  <= '0;
    end else if (accept) begin
      vsew_q <= dec_vsew;
      evl_q  <= dec_evl;
      last_q <= dec_last;
      vd_q   <= cmd_vd;
      vs1_q  <= cmd_vs1;
      vs2_q  <= cmd_vs2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end

  // ERR and ZERO are one-cycle completion states that still take the next command.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE, ERR, ZERO: begin
        state_d = IDLE;
        if (accept) begin
          if (!dec_legal)          state_d = ERR;
          else if (dec_evl == '0)  state_d = ZERO;
          else begin
            state_d = ISSUE;
            beat_d  = '0;
          end
        end
      end
      ISSUE: begin
        if (beat_q == last_q) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
      DRAIN: begin
        if (drain_q == 3'(ALU_LAT - 1)) state_d = IDLE;
        else                            drain_d = drain_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next-cycle output values, so every issue/control output comes straight from a flop.
  always_comb begin
    cur_vsew    = accept ? dec_vsew : vsew_q;
    cur_evl     = accept ? dec_evl  : evl_q;
    cur_vd      = accept ? cmd_vd   : vd_q;
    cur_vs1     = accept ? cmd_vs1  : vs1_q;
    cur_vs2     = accept ? cmd_vs2  : vs2_q;
    issuing_d   = (state_d == ISSUE);
    idle_like_d = (state_d == IDLE) || (state_d == ERR) || (state_d == ZERO);
    bmask_d     = '0;
    raA_d       = '0;
    raB_d       = '0;
    issue_wa_d  = '0;
    if (issuing_d) begin
      bmask_d    = beat_bmask(cur_evl, beat_d, cur_vsew);
      raA_d      = cur_vs1 + 5'(beat_d);
      raB_d      = cur_vs2 + 5'(beat_d);
      issue_wa_d = cur_vd + 5'(beat_d);
    end
    done_d = ((state_q == DRAIN) && (state_d == IDLE)) || (state_d == ZERO);
    err_d  = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      raA       <= '0;
      raB       <= '0;
      alu_valid <= 1'b0;
      alu_bmask <= '0;
      issue_wa  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      cmd_ready <= idle_like_d;
      busy      <= !idle_like_d;
      raA       <= raA_d;
      raB       <= raB_d;
      alu_valid <= |bmask_d;
      alu_bmask <= bmask_d;
      issue_wa  <= issue_wa_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  vrf_wb_pipe #(.LAT(ALU_LAT)) u_wb_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (alu_valid),
    .in_wa     (issue_wa),
    .out_valid (wen),
    .out_wa    (wa)
  );

  // Write data is the ALU result passing through, held at zero outside write slots.
  assign wd = wen ? alu_res : '0;

endmodule

// File: tb/tb_vrf_group_sequencer.sv
// Directed bench for vrf_group_sequencer: group issue, vl clamping, illegal/zero commands, mid-op reset.
module tb_vrf_group_sequencer;

  localparam int unsigned LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [4:0]   cmd_vd, cmd_vs1, cmd_vs2;
  logic [6:0]   vtype;
  logic [8:0]   vl;
  logic [4:0]   raA, raB, wa;
  logic         alu_valid, wen, busy, done, err;
  logic [15:0]  alu_bmask;
  logic [127:0] alu_res, wd;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vrf_group_sequencer #(.ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_vd(cmd_vd), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .vtype(vtype), .vl(vl),
    .raA(raA), .raB(raB), .alu_valid(alu_valid), .alu_bmask(alu_bmask), .alu_res(alu_res),
    .wa(wa), .wd(wd), .wen(wen), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present a command for one cycle; returns at the negedge of the cycle after acceptance.
  task automatic accept(input logic [6:0] vt, input int len, input int vd, input int vs1, input int vs2);
    chk("cmd_ready_at_accept", cmd_ready, 1);
    vtype     = vt;
    vl        = 9'(len);
    cmd_vd    = 5'(vd);
    cmd_vs1   = 5'(vs1);
    cmd_vs2   = 5'(vs2);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Walk a legal command cycle by cycle from acceptance+1 to its done cycle.
  task automatic run_group(input int lmul, input int vd, input int vs1, input int vs2,
                           input logic [127:0] masks);
    int total;
    total = lmul + LAT + 1;
    for (int c = 1; c <= total; c++) begin
      logic [15:0] m;
      int b, w;
      alu_res = {4{32'hA5A5_5A5A ^ 32'(c)}};
      #1;
      b = c - 1;
      w = c - 1 - int'(LAT);
      if (c <= lmul) begin
        m = masks[16*b +: 16];
        chk("raA", raA, 5'(vs1 + b));
        chk("raB", raB, 5'(vs2 + b));
        chk("alu_bmask", alu_bmask, m);
        chk("alu_valid", alu_valid, |m);
      end else begin
        chk("alu_valid_idle", alu_valid, 0);
      end
      if (w >= 0 && w < lmul) begin
        m = masks[16*w +: 16];
        chk("wen_slot", wen, |m);
        if (|m) begin
          chk("wa", wa, 5'(vd + w));
          chk("wd", wd, alu_res);
        end
      end else begin
        chk("wen_none", wen, 0);
      end
      chk("done", done, c == total);
      chk("busy", busy, c < total);
      chk("err_quiet", err, 0);
      if (c < total) @(negedge clk);
    end
  endtask

  task automatic err_case(input logic [6:0] vt, input int vd);
    accept(vt, 16, vd, 0, 0);
    chk("err_pulse", err, 1);
    chk("err_no_issue", alu_valid, 0);
    chk("err_no_wen", wen, 0);
    chk("err_no_done", done, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("err_after", err, 0);
      chk("err_after_issue", alu_valid, 0);
      chk("err_after_wen", wen, 0);
    end
  endtask

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_vd    = '0;
    cmd_vs1   = '0;
    cmd_vs2   = '0;
    vtype     = '0;
    vl        = '0;
    alu_res   = {4{32'hDEAD_BEEF}};
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_raA", raA, 0);
    chk("rst_raB", raB, 0);
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_bmask", alu_bmask, 0);
    chk("rst_wen", wen, 0);
    chk("rst_wa", wa, 0);
    chk("rst_wd", wd, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    @(negedge clk);

    // SEW8 LMUL1, full register.
    accept(7'b1_000_000, 16, 3, 1, 2);
    run_group(1, 3, 1, 2, 128'h0000_0000_0000_0000_0000_0000_0000_FFFF);

    // SEW32 LMUL4, vl=10: partial third beat, empty fourth; taken back-to-back on done.
    accept(7'b1_010_010, 10, 8, 4, 12);
    run_group(4, 8, 4, 12, {64'h0, 16'h0000, 16'h00FF, 16'hFFFF, 16'hFFFF});

    // SEW8 LMUL8, vl=200 clamps to VLMAX=128.
    accept(7'b1_000_011, 200, 0, 0, 0);
    run_group(8, 0, 0, 0, {8{16'hFFFF}});

    // Illegal: misaligned vd, vtype invalid, fractional vlmul.
    err_case(7'b1_000_010, 6);
    err_case(7'b0_000_000, 0);
    err_case(7'b1_000_101, 0);

    // vl=0 completes immediately; next command held valid is taken in the done cycle.
    accept(7'b1_000_000, 0, 3, 1, 2);
    chk("zero_done", done, 1);
    chk("zero_no_issue", alu_valid, 0);
    chk("zero_no_wen", wen, 0);
    chk("zero_ready", cmd_ready, 1);
    accept(7'b1_000_000, 16, 5, 6, 7);
    run_group(1, 5, 6, 7, 128'h0000_0000_0000_0000_0000_0000_0000_FFFF);

    // Reset in the middle of an LMUL=8 group.
    accept(7'b1_000_011, 128, 16, 8, 24);
    chk("pre_rst_issue", alu_valid, 1);
    chk("pre_rst_raA", raA, 8);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_wen", wen, 0);
    chk("mid_rst_alu_valid", alu_valid, 0);
    chk("mid_rst_bmask", alu_bmask, 0);
    chk("mid_rst_raA", raA, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_wd", wd, 0);
    chk("mid_rst_done", done, 0);
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("post_rst_wen", wen, 0);
      chk("post_rst_done", done, 0);
      chk("post_rst_issue", alu_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
